// File: rtl/tlb_lookup_responder.sv
// Joint TLB: answers I/D micro-TLB miss lookups one cycle after the VPN2 is
// presented, executes TLBWI/TLBWR/TLBR/TLBP and maintains the Random counter.
// Entry layout (MSB first): VPN2[19] ASID[8] G PFN0[20] C0[3] D0 V0
//                           PFN1[20] C1[3] D1 V1  -> 78 bits.
module tlb_lookup_responder #(
  parameter  int TLB_ENTRY_NUM = 16,
  localparam int IDX_W         = $clog2(TLB_ENTRY_NUM),
  localparam int EW            = 78
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [18:0]      I_VPN2,
  input  logic [18:0]      D_VPN2,
  input  logic [7:0]       CP0_EntryHi_ASID,
  output logic [EW-1:0]    I_TLBEntry,
  output logic             s0_found,
  output logic [EW-1:0]    D_TLBEntry,
  output logic             s1_found,
  input  logic             TLBWI,
  input  logic             TLBWR,
  input  logic [IDX_W-1:0] Wr_Index,
  input  logic [EW-1:0]    Wr_Entry,
  input  logic [IDX_W-1:0] CP0_Wired,
  input  logic             CP0_Wired_Wr,
  input  logic             TLBR,
  input  logic [IDX_W-1:0] Rd_Index,
  output logic [EW-1:0]    Rd_Entry,
  input  logic             TLBP,
  input  logic [18:0]      Probe_VPN2,
  input  logic [7:0]       Probe_ASID,
  output logic             Probe_Found,
  output logic [IDX_W-1:0] Probe_Index,
  output logic [IDX_W-1:0] Random,
  output logic             TLBBuffer_Flush
);

  localparam logic [IDX_W-1:0] TOP = IDX_W'(TLB_ENTRY_NUM - 1);

  logic [EW-1:0]    tlb_q [TLB_ENTRY_NUM];
  logic [18:0]      i_vpn_q, d_vpn_q;
  logic [7:0]       asid_q;
  logic [EW-1:0]    rd_q;
  logic             pf_q, flush_q;
  logic [IDX_W-1:0] pi_q, rand_q, rand_d;

  logic             wr_en;
  logic [IDX_W-1:0] wr_idx;
  logic             i_hit, d_hit, p_hit;
  logic [IDX_W-1:0] i_idx, d_idx, p_idx;

  // Entry hit: VPN2 equal and either global or same ASID.
  function automatic logic match(logic [EW-1:0] e, logic [18:0] vpn, logic [7:0] asid);
    return (e[77:59] == vpn) && (e[50] || (e[58:51] == asid));
  endfunction

  // TLBWI takes priority over TLBWR so only one entry is ever written.
  assign wr_en  = TLBWI | TLBWR;
  assign wr_idx = TLBWI ? Wr_Index : rand_q;

  // Three parallel priority searches; scanning downward lets the lowest index win.
  always_comb begin
    i_hit = 1'b0; i_idx = '0;
    d_hit = 1'b0; d_idx = '0;
    p_hit = 1'b0; p_idx = '0;
    for (int k = TLB_ENTRY_NUM - 1; k >= 0; k--) begin
      if (match(tlb_q[k], i_vpn_q, asid_q))        begin i_hit = 1'b1; i_idx = IDX_W'(k); end
      if (match(tlb_q[k], d_vpn_q, asid_q))        begin d_hit = 1'b1; d_idx = IDX_W'(k); end
      if (match(tlb_q[k], Probe_VPN2, Probe_ASID)) begin p_hit = 1'b1; p_idx = IDX_W'(k); end
    end
  end

  // Random wraps to the top on Wired write, on reaching Wired, or when Wired leaves no range.
  always_comb begin
    rand_d = rand_q - 1'b1;
    if (CP0_Wired_Wr || (CP0_Wired >= TOP) || (rand_q == CP0_Wired))
      rand_d = TOP;
  end

  // Entry array; lookups compare the post-write contents combinationally.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int k = 0; k < TLB_ENTRY_NUM; k++) tlb_q[k] <= '0;
    end else if (wr_en) begin
      tlb_q[wr_idx] <= Wr_Entry;
    end
  end

  // Lookup inputs, TLBR/TLBP results (pre-write contents), Random and flush.
  always_ff @(posedge clk) begin
    if (!rst) begin
      i_vpn_q <= '0;
      d_vpn_q <= '0;
      asid_q  <= '0;
      rd_q    <= '0;
      pf_q    <= 1'b0;
      pi_q    <= '0;
      rand_q  <= TOP;
      flush_q <= 1'b0;
    end else begin
      i_vpn_q <= I_VPN2;
      d_vpn_q <= D_VPN2;
      asid_q  <= CP0_EntryHi_ASID;
      if (TLBR) rd_q <= tlb_q[Rd_Index];
      if (TLBP) begin
        pf_q <= p_hit;
        pi_q <= p_idx;
      end
      rand_q  <= rand_d;
      flush_q <= wr_en;
    end
  end

  assign I_TLBEntry      = i_hit ? tlb_q[i_idx] : '0;
  assign s0_found        = i_hit;
  assign D_TLBEntry      = d_hit ? tlb_q[d_idx] : '0;
  assign s1_found        = d_hit;
  assign Rd_Entry        = rd_q;
  assign Probe_Found     = pf_q;
  assign Probe_Index     = pi_q;
  assign Random          = rand_q;
  assign TLBBuffer_Flush = flush_q;

endmodule

// File: tb/tb_tlb_lookup_responder.sv
// Bench for tlb_lookup_responder: a behavioural model checked every cycle
// plus directed scenarios with literal expectations.
module tb_tlb_lookup_responder;
  localparam int N  = 16;
  localparam int IW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [18:0]   I_VPN2, D_VPN2, Probe_VPN2;
  logic [7:0]    CP0_EntryHi_ASID, Probe_ASID;
  logic [77:0]   I_TLBEntry, D_TLBEntry, Wr_Entry, Rd_Entry;
  logic          s0_found, s1_found;
  logic          TLBWI, TLBWR, CP0_Wired_Wr, TLBR, TLBP;
  logic [IW-1:0] Wr_Index, CP0_Wired, Rd_Index, Probe_Index, Random;
  logic          Probe_Found, TLBBuffer_Flush;

  tlb_lookup_responder #(.TLB_ENTRY_NUM(N)) dut (
    .clk(clk), .rst(rst), .I_VPN2(I_VPN2), .D_VPN2(D_VPN2),
    .CP0_EntryHi_ASID(CP0_EntryHi_ASID), .I_TLBEntry(I_TLBEntry), .s0_found(s0_found),
    .D_TLBEntry(D_TLBEntry), .s1_found(s1_found), .TLBWI(TLBWI), .TLBWR(TLBWR),
    .Wr_Index(Wr_Index), .Wr_Entry(Wr_Entry), .CP0_Wired(CP0_Wired),
    .CP0_Wired_Wr(CP0_Wired_Wr), .TLBR(TLBR), .Rd_Index(Rd_Index), .Rd_Entry(Rd_Entry),
    .TLBP(TLBP), .Probe_VPN2(Probe_VPN2), .Probe_ASID(Probe_ASID),
    .Probe_Found(Probe_Found), .Probe_Index(Probe_Index), .Random(Random),
    .TLBBuffer_Flush(TLBBuffer_Flush)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(string nm, logic [77:0] act, logic [77:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [77:0] mk(logic [18:0] vpn, logic [7:0] asid, logic g,
                                     logic [19:0] pfn0, logic [2:0] c0, logic d0, logic v0,
                                     logic [19:0] pfn1, logic [2:0] c1, logic d1, logic v1);
    return {vpn, asid, g, pfn0, c0, d0, v0, pfn1, c1, d1, v1};
  endfunction

  // ---------------- behavioural model ----------------
  logic [77:0] m_tlb [N];
  logic [18:0] m_ivpn, m_dvpn;
  logic [7:0]  m_asid;
  logic [77:0] m_rd;
  logic        m_pf, m_flush;
  int          m_pi, m_rand;
  logic        started = 1'b0;

  // First matching index scanning upward, -1 when nothing matches.
  function automatic int find(logic [18:0] vpn, logic [7:0] asid);
    for (int k = 0; k < N; k++)
      if (m_tlb[k][77:59] == vpn && (m_tlb[k][50] || m_tlb[k][58:51] == asid)) return k;
    return -1;
  endfunction

  function automatic logic [77:0] lookup(logic [18:0] vpn, logic [7:0] asid);
    int f;
    f = find(vpn, asid);
    return (f < 0) ? 78'd0 : m_tlb[f];
  endfunction

  always @(posedge clk) begin
    int f;
    if (!rst) begin
      for (int k = 0; k < N; k++) m_tlb[k] <= '0;
      m_ivpn <= '0; m_dvpn <= '0; m_asid <= '0;
      m_rd <= '0; m_pf <= 1'b0; m_pi <= 0; m_rand <= N - 1; m_flush <= 1'b0;
      started <= 1'b1;
    end else begin
      m_ivpn <= I_VPN2; m_dvpn <= D_VPN2; m_asid <= CP0_EntryHi_ASID;
      if (TLBR) m_rd <= m_tlb[Rd_Index];
      if (TLBP) begin
        f = find(Probe_VPN2, Probe_ASID);
        m_pf <= (f >= 0);
        m_pi <= (f >= 0) ? f : 0;
      end
      if (TLBWI)      m_tlb[Wr_Index] <= Wr_Entry;
      else if (TLBWR) m_tlb[m_rand]   <= Wr_Entry;
      m_flush <= TLBWI | TLBWR;
      if (CP0_Wired_Wr || int'(CP0_Wired) >= N - 1 || m_rand == int'(CP0_Wired)) m_rand <= N - 1;
      else m_rand <= m_rand - 1;
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (started) begin
      chk("m_I_entry", I_TLBEntry, lookup(m_ivpn, m_asid));
      chk("m_s0_found", s0_found, find(m_ivpn, m_asid) >= 0);
      chk("m_D_entry", D_TLBEntry, lookup(m_dvpn, m_asid));
      chk("m_s1_found", s1_found, find(m_dvpn, m_asid) >= 0);
      chk("m_Rd_Entry", Rd_Entry, m_rd);
      chk("m_Probe_Found", Probe_Found, m_pf);
      chk("m_Probe_Index", Probe_Index, 78'(m_pi));
      chk("m_Random", Random, 78'(m_rand));
      chk("m_Flush", TLBBuffer_Flush, m_flush);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [77:0] e3, e3g, e4, e9, e7, e10, ea, eb, ex;
  int rv;

  initial begin
    e3  = mk(19'h00010, 8'h05, 1'b0, 20'h12345, 3'd3, 1'b1, 1'b1, 20'h0, 3'd0, 1'b0, 1'b0);
    e3g = mk(19'h00010, 8'h05, 1'b1, 20'h12345, 3'd3, 1'b1, 1'b1, 20'h54321, 3'd2, 1'b0, 1'b1);
    e4  = mk(19'h7FFF0, 8'h11, 1'b0, 20'hAAAAA, 3'd1, 1'b0, 1'b1, 20'h0, 3'd0, 1'b0, 1'b0);
    e9  = mk(19'h7FFF0, 8'h11, 1'b0, 20'hBBBBB, 3'd1, 1'b0, 1'b1, 20'h0, 3'd0, 1'b0, 1'b0);
    e7  = mk(19'h00777, 8'h07, 1'b0, 20'h77777, 3'd7, 1'b1, 1'b1, 20'h7, 3'd7, 1'b1, 1'b1);
    e10 = mk(19'h0A0A0, 8'h0A, 1'b1, 20'hA0A0A, 3'd2, 1'b1, 1'b0, 20'h1, 3'd1, 1'b0, 1'b1);
    ea  = mk(19'h00555, 8'h01, 1'b0, 20'h5A5A5, 3'd5, 1'b0, 1'b1, 20'h2, 3'd0, 1'b0, 1'b0);
    eb  = mk(19'h00556, 8'h02, 1'b1, 20'hB5B5B, 3'd6, 1'b1, 1'b1, 20'h3, 3'd0, 1'b0, 1'b0);
    ex  = mk(19'h0CCCC, 8'h0C, 1'b1, 20'hCCCCC, 3'd4, 1'b1, 1'b1, 20'h4, 3'd4, 1'b1, 1'b1);

    rst = 1'b0; I_VPN2 = 19'h0; D_VPN2 = 19'h0; CP0_EntryHi_ASID = 8'h0;
    TLBWI = 0; TLBWR = 0; Wr_Index = '0; Wr_Entry = '0; CP0_Wired = 4'd2; CP0_Wired_Wr = 0;
    TLBR = 0; Rd_Index = '0; TLBP = 0; Probe_VPN2 = '0; Probe_ASID = '0;
    step(); step();

    // reset state: zeroed entry 0 matches the zeroed lookup registers
    chk("rst_Random", Random, 78'd15);
    chk("rst_Rd_Entry", Rd_Entry, 78'd0);
    chk("rst_Probe_Found", Probe_Found, 78'd0);
    chk("rst_Flush", TLBBuffer_Flush, 78'd0);
    chk("rst_s0_zero_hit", s0_found, 78'd1);

    // Random sequence with Wired=2; TLBWR when Random is 7
    rst = 1'b1;
    for (int i = 0; i < 14; i++) begin
      step();
      chk("rand_seq", Random, (i < 13) ? 78'(14 - i) : 78'd15);
      if (Random == 4'd7) begin TLBWR = 1'b1; Wr_Entry = e7; end
      else TLBWR = 1'b0;
    end
    TLBWR = 1'b0;
    step(); step();
    CP0_Wired_Wr = 1'b1;
    step();
    CP0_Wired_Wr = 1'b0;
    chk("wired_wr_rand", Random, 78'd15);
    TLBR = 1'b1; Rd_Index = 4'd7;
    step();
    TLBR = 1'b0;
    chk("tlbwr_entry7", Rd_Entry, e7);
    step();
    chk("rd_hold", Rd_Entry, e7);

    // TLBWI + D-side lookup
    TLBWI = 1'b1; Wr_Index = 4'd3; Wr_Entry = e3;
    step();
    TLBWI = 1'b0;
    chk("flush_after_wr", TLBBuffer_Flush, 78'd1);
    D_VPN2 = 19'h00010; CP0_EntryHi_ASID = 8'h05;
    step();
    chk("flush_one_cycle", TLBBuffer_Flush, 78'd0);
    chk("d_found", s1_found, 78'd1);
    chk("d_pfn0", D_TLBEntry[49:30], 78'h12345);

    // ASID mismatch, then global entry; write visible at the same edge
    CP0_EntryHi_ASID = 8'h06;
    step();
    chk("asid_miss_found", s1_found, 78'd0);
    chk("asid_miss_entry", D_TLBEntry, 78'd0);
    TLBWI = 1'b1; Wr_Entry = e3g;
    step();
    TLBWI = 1'b0;
    chk("global_hit", s1_found, 78'd1);

    // I and D on the same entry
    I_VPN2 = 19'h00010;
    step();
    chk("i_same_found", s0_found, 78'd1);
    chk("i_same_entry", I_TLBEntry, e3g);
    chk("d_same_entry", D_TLBEntry, e3g);

    // probe: two matches, lowest index wins; probe ASID differs from EntryHi ASID
    TLBWI = 1'b1; Wr_Index = 4'd9; Wr_Entry = e9;
    step();
    Wr_Index = 4'd4; Wr_Entry = e4;
    step();
    TLBWI = 1'b0;
    TLBP = 1'b1; Probe_VPN2 = 19'h7FFF0; Probe_ASID = 8'h11;
    I_VPN2 = 19'h7FFF0; CP0_EntryHi_ASID = 8'h11;
    step();
    chk("probe_found", Probe_Found, 78'd1);
    chk("probe_idx", Probe_Index, 78'd4);
    chk("i_multi_lowest", I_TLBEntry, e4);
    Probe_VPN2 = 19'h12345;
    step();
    TLBP = 1'b0;
    chk("probe_miss_found", Probe_Found, 78'd0);
    chk("probe_miss_idx", Probe_Index, 78'd0);

    // TLBWI and TLBWR together: only Wr_Index written
    if (Random == 4'd10) step();
    rv = int'(Random);
    TLBWI = 1'b1; TLBWR = 1'b1; Wr_Index = 4'd10; Wr_Entry = e10;
    step();
    TLBWI = 1'b0; TLBWR = 1'b0;
    TLBR = 1'b1; Rd_Index = 4'd10;
    step();
    chk("dual_wr_idx10", Rd_Entry, e10);
    Rd_Index = 4'(rv);
    step();
    TLBR = 1'b0;

    // TLBWI and TLBR on the same index: read returns pre-write value
    TLBWI = 1'b1; Wr_Index = 4'd5; Wr_Entry = ea;
    step();
    Wr_Entry = eb; TLBR = 1'b1; Rd_Index = 4'd5;
    step();
    TLBWI = 1'b0;
    chk("rd_prewrite", Rd_Entry, ea);
    step();
    TLBR = 1'b0;
    chk("rd_postwrite", Rd_Entry, eb);

    // Wired at the top keeps Random pinned
    CP0_Wired = 4'd15;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("wired_top_rand", Random, 78'd15);
    end
    CP0_Wired = 4'd2;
    step(); step();

    // reset mid-operation overrides a pending write/read/probe
    TLBP = 1'b1; Probe_VPN2 = 19'h7FFF0; Probe_ASID = 8'h11;
    step();
    rst = 1'b0; TLBWI = 1'b1; Wr_Index = 4'd12; Wr_Entry = ex; TLBR = 1'b1; Rd_Index = 4'd4;
    step();
    TLBWI = 1'b0; TLBP = 1'b0;
    chk("mid_rst_Random", Random, 78'd15);
    chk("mid_rst_Rd", Rd_Entry, 78'd0);
    chk("mid_rst_Probe_Found", Probe_Found, 78'd0);
    chk("mid_rst_Probe_Index", Probe_Index, 78'd0);
    chk("mid_rst_Flush", TLBBuffer_Flush, 78'd0);
    rst = 1'b1; Rd_Index = 4'd12;
    step();
    TLBR = 1'b0;
    chk("mid_rst_no_write", Rd_Entry, 78'd0);
    chk("post_rst_flush", TLBBuffer_Flush, 78'd0);
    step(); step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/tlb_lookup_responder.md
Name: tlb_lookup_responder

Overview:
Main joint TLB that answers translation lookups from the instruction and data micro-TLB buffers. Each buffer presents a VPN2 on a miss; this block returns the matching entry and a found flag one cycle later, which lands in the buffer's SEARCH cycle. It also executes the CP0 TLB instructions TLBWI, TLBWR, TLBR and TLBP, and maintains the Random counter. After any TLB write it pulses TLBBuffer_Flush so both micro-TLBs drop stale translations.

Parameters:
TLB_ENTRY_NUM, 16, number of joint TLB entries (power of two, 4..32)
IDX_W, $clog2(TLB_ENTRY_NUM), index width (derived, not overridden)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-low
I_VPN2  in  19  instruction-side lookup VPN2 (vaddr[31:13])
D_VPN2  in  19  data-side lookup VPN2
CP0_EntryHi_ASID  in  8  current ASID used by the I/D lookups
I_TLBEntry  out  TLB_Entry  instruction-side matched entry
s0_found  out  1  instruction-side hit
D_TLBEntry  out  TLB_Entry  data-side matched entry
s1_found  out  1  data-side hit
TLBWI  in  1  write entry Wr_Index
TLBWR  in  1  write entry at Random
Wr_Index  in  IDX_W  CP0 Index for TLBWI
Wr_Entry  in  TLB_Entry  {EntryHi, EntryLo0, EntryLo1} fields to write
CP0_Wired  in  IDX_W  Wired register value
CP0_Wired_Wr  in  1  Wired is being written this cycle
TLBR  in  1  read request
Rd_Index  in  IDX_W  index for TLBR
Rd_Entry  out  TLB_Entry  TLBR result
TLBP  in  1  probe request
Probe_VPN2  in  19  EntryHi.VPN2 to probe
Probe_ASID  in  8  EntryHi.ASID to probe
Probe_Found  out  1  probe hit
Probe_Index  out  IDX_W  probe hit index
Random  out  IDX_W  Random register
TLBBuffer_Flush  out  1  one-cycle flush to I/D micro-TLBs

Behaviour:
- TLB_Entry is packed: VPN2[19], ASID[8], G, PFN0[20], C0[3], D0, V0, PFN1[20], C1[3], D1, V1.
- Hit rule for entry k: VPN2 equal, and (G==1 or ASID equal). With multiple hits, the lowest index wins. There is no per-entry valid bit.
- Lookup latency:
  - I_VPN2, D_VPN2 and CP0_EntryHi_ASID are registered at every rising edge.
  - The registered values are compared against the current array contents.
  - Outputs are valid during the next cycle.
  - On a miss, the entry output is all-zero and the found flag is 0.
- Write/lookup ordering: a write at edge t is visible to a lookup whose VPN2 was also registered at edge t.
- Writes:
  - TLBWI writes entry[Wr_Index]; TLBWR writes entry[Random]. Both take effect at the edge.
  - If TLBWI and TLBWR are both high in the same cycle, TLBWI wins and exactly one entry is written.
- TLBBuffer_Flush is 1 in the cycle after any write and 0 otherwise.
- TLBR: Rd_Entry is registered from entry[Rd_Index] at the edge where TLBR=1, and holds otherwise. If TLBR and a write to the same index occur in the same cycle, Rd_Entry gets the pre-write value.
- TLBP:
  - Probe_Found and Probe_Index are registered at the edge where TLBP=1, and hold otherwise.
  - The probe uses Probe_ASID, not CP0_EntryHi_ASID.
  - The probe compares pre-write contents if a write occurs in the same cycle.
  - On a miss, Probe_Index is 0.
- Random:
  - Reset value is TLB_ENTRY_NUM-1.
  - Decrements by 1 every cycle.
  - When Random==CP0_Wired, the next value is TLB_ENTRY_NUM-1 (wrap).
  - CP0_Wired_Wr forces the next value to TLB_ENTRY_NUM-1; this has priority over decrement and wrap.
  - If CP0_Wired >= TLB_ENTRY_NUM-1, Random stays at TLB_ENTRY_NUM-1.
- Reset (rst==0 at an edge):
  - All entries are cleared to zero.
  - Lookup registers are cleared, so s0_found and s1_found read as hits on zeroed entry 0 only if VPN2/ASID match zero.
  - Rd_Entry=0, Probe_Found=0, Probe_Index=0, Random=TLB_ENTRY_NUM-1, TLBBuffer_Flush=0.
  - Reset overrides any TLBWI/TLBWR/TLBR/TLBP asserted in the same cycle; no write occurs.
- There is no state machine beyond the lookup/probe registers and Random. The I and D ports are fully independent and may hit the same entry in the same cycle.

Test Plan:
- Write: TLBWI, Wr_Index=3, Wr_Entry{VPN2=19'h00010, ASID=8'h05, G=0, PFN0=20'h12345, V0=1, D0=1}. Then D_VPN2=19'h00010, ASID=8'h05 -> next cycle s1_found=1, D_TLBEntry.PFN0=20'h12345. TLBBuffer_Flush=1 exactly one cycle after the write.
- ASID/global match: same entry looked up with ASID=8'h06 -> s1_found=0, D_TLBEntry=0. Rewrite the entry with G=1 -> ASID=8'h06 hits.
- Random: Wired=2 after reset -> Random sequence 15,14,...,2,15. TLBWR at Random=7 writes entry 7 (read back via TLBR, Rd_Index=7). CP0_Wired_Wr mid-sequence -> Random=15 next cycle.
- Probe: entries 4 and 9 both match VPN2=19'h7FFF0 -> Probe_Found=1, Probe_Index=4. Unmatched probe -> Probe_Found=0, Probe_Index=0.
- Same cycle: TLBWI and TLBWR together -> only Wr_Index written. TLBWI index 5 with TLBR index 5 -> Rd_Entry returns the old contents. I_VPN2 and D_VPN2 hitting the same entry -> both found=1.
- Reset mid-operation: rst=0 together with TLBWI pending -> no write. All outputs at reset values. Random=15 on the first cycle after reset.
